// File: rtl/mod_n_counter.sv
// Free-running modulo counter over 0..MAX_VAL that never produces SKIP_VAL.
// Define MOD_N_COUNTER_ASSERT_EN to compile in simulation-only sequence checks.
module mod_n_counter #(
  parameter int LENGTH   = 4,
  parameter int MAX_VAL  = 7,
  parameter int SKIP_VAL = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LENGTH-1:0] counter
);

  localparam logic [LENGTH-1:0] MAX_L  = LENGTH'(MAX_VAL);
  localparam logic [LENGTH-1:0] SKIP_L = LENGTH'(SKIP_VAL);
  localparam logic [LENGTH-1:0] ONE_L  = LENGTH'(1);
  localparam logic [LENGTH-1:0] ZERO_L = {LENGTH{1'b0}};

  if ((MAX_VAL >= (1 << LENGTH)) || (SKIP_VAL < 1) || (SKIP_VAL > MAX_VAL)) begin : g_bad_params
    $fatal(1, "mod_n_counter: illegal LENGTH/MAX_VAL/SKIP_VAL combination");
  end

  logic [LENGTH-1:0] counter_d;
  logic [LENGTH-1:0] counter_q;
  logic [LENGTH-1:0] inc_s;

  // Next-count: the skipped value and anything above MAX_VAL also fall back to 0
  always_comb begin
    inc_s     = counter_q + ONE_L;
    counter_d = ZERO_L;
    if ((counter_q == SKIP_L) || (counter_q >= MAX_L)) begin
      counter_d = ZERO_L;
    end else if (inc_s == SKIP_L) begin
      counter_d = (SKIP_L == MAX_L) ? ZERO_L : (SKIP_L + ONE_L);
    end else begin
      counter_d = inc_s;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= ZERO_L;
    end else begin
      counter_q <= counter_d;
    end
  end

  assign counter = counter_q;

`ifdef MOD_N_COUNTER_ASSERT_EN
  mod_n_counter_chk #(
    .LENGTH   (LENGTH),
    .MAX_VAL  (MAX_VAL),
    .SKIP_VAL (SKIP_VAL)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .counter (counter_q)
  );
`else
`endif

endmodule

`ifdef MOD_N_COUNTER_ASSERT_EN
module mod_n_counter_chk #(
  parameter int LENGTH   = 4,
  parameter int MAX_VAL  = 7,
  parameter int SKIP_VAL = 4
) (
  input logic              clk,
  input logic              rst,
  input logic [LENGTH-1:0] counter
);

  localparam logic [LENGTH-1:0] MAX_L  = LENGTH'(MAX_VAL);
  localparam logic [LENGTH-1:0] SKIP_L = LENGTH'(SKIP_VAL);
  localparam logic [LENGTH-1:0] ONE_L  = LENGTH'(1);

  logic              seen_q;
  logic              chk_q;
  logic [LENGTH-1:0] exp_q;

  // Track whether reset has occurred and predict the next value of a plain count step
  always @(posedge clk) begin
    if (rst) begin
      seen_q <= 1'b1;
    end
    chk_q <= (seen_q === 1'b1) && !rst;
    if ((counter == MAX_L) || (counter == SKIP_L) || (counter > MAX_L)) begin
      exp_q <= {LENGTH{1'b0}};
    end else if ((counter + ONE_L) == SKIP_L) begin
      exp_q <= (SKIP_L == MAX_L) ? {LENGTH{1'b0}} : (SKIP_L + ONE_L);
    end else begin
      exp_q <= counter + ONE_L;
    end
  end

  // Range and sequence checks, active only once reset has been seen
  always @(posedge clk) begin
    if (seen_q === 1'b1) begin
      assert (counter != SKIP_L) else $error("mod_n_counter: skipped value produced");
      assert (counter <= MAX_L) else $error("mod_n_counter: value above MAX_VAL");
      if (chk_q) begin
        assert (counter == exp_q) else $error("mod_n_counter: sequence rule broken");
      end
    end
  end

endmodule
`endif

// File: tb/tb_mod_n_counter.sv
// Directed self-checking bench for mod_n_counter (default mod-7 and a 14-state override).
module tb_mod_n_counter;

  logic       clk;
  logic       rst;
  logic [3:0] counter;
  logic [3:0] counter_w;

  int checks;
  int errors;

  mod_n_counter dut (
    .clk     (clk),
    .rst     (rst),
    .counter (counter)
  );

  mod_n_counter #(
    .LENGTH   (4),
    .MAX_VAL  (14),
    .SKIP_VAL (14)
  ) dut_w (
    .clk     (clk),
    .rst     (rst),
    .counter (counter_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if (counter !== 4'd0) begin
      errors++;
      $display("FAIL reset_default got %0d want 0", counter);
    end
    checks++;
    if (counter_w !== 4'd0) begin
      errors++;
      $display("FAIL reset_wide got %0d want 0", counter_w);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    logic [3:0] exp_seq [8] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd0, 4'd1};
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (counter !== exp_seq[i]) begin
        errors++;
        $display("FAIL sequence step %0d got %0d want %0d", i, counter, exp_seq[i]);
      end
    end
  endtask

  task automatic test_two_periods();
    logic [3:0] period [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7};
    logic [3:0] prev;
    int zeros;
    zeros = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    prev = 4'd0;
    for (int i = 1; i <= 14; i++) begin
      step();
      checks++;
      if (counter !== period[i % 7]) begin
        errors++;
        $display("FAIL two_periods step %0d got %0d want %0d", i, counter, period[i % 7]);
      end
      if (prev == 4'd7) begin
        checks++;
        if (counter !== 4'd0) begin
          errors++;
          $display("FAIL wrap_after_7 step %0d got %0d want 0", i, counter);
        end
      end
      if (counter == 4'd0) zeros++;
      prev = counter;
    end
    checks++;
    if (zeros != 2) begin
      errors++;
      $display("FAIL two_periods_zero_count got %0d want 2", zeros);
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (counter !== 4'd5) begin
      errors++;
      $display("FAIL mid_reset_pre got %0d want 5", counter);
    end
    rst = 1'b1;
    step();
    checks++;
    if (counter !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset_edge got %0d want 0", counter);
    end
    rst = 1'b0;
    step();
    checks++;
    if (counter !== 4'd1) begin
      errors++;
      $display("FAIL mid_reset_resume got %0d want 1", counter);
    end
  endtask

  task automatic test_reset_hold();
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (counter !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold edge %0d got %0d want 0", i, counter);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (counter !== 4'd1) begin
      errors++;
      $display("FAIL reset_hold_release got %0d want 1", counter);
    end
  endtask

  task automatic test_illegal(input logic [3:0] bad);
    force dut.counter_q = bad;
    #1;
    release dut.counter_q;
    step();
    checks++;
    if (counter !== 4'd0) begin
      errors++;
      $display("FAIL illegal_%0d_recover got %0d want 0", bad, counter);
    end
    step();
    checks++;
    if (counter !== 4'd1) begin
      errors++;
      $display("FAIL illegal_%0d_resume got %0d want 1", bad, counter);
    end
  endtask

  task automatic test_wide();
    logic [3:0] exp_v;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      exp_v = 4'(i % 14);
      checks++;
      if (counter_w !== exp_v) begin
        errors++;
        $display("FAIL wide step %0d got %0d want %0d", i, counter_w, exp_v);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_two_periods();
    test_mid_reset();
    test_reset_hold();
    test_illegal(4'd4);
    test_illegal(4'd12);
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
